// File: rtl/wb_stage.sv
// wb_stage: pipeline writeback stage.
//   Extracts and extends load data, selects the regfile write value, drives the
//   regfile write port, keeps a 1-deep forwarding history of the last retired
//   write, counts retired instructions and flags misaligned loads (sticky).
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   valid_in, stall_in, flush_in    pipeline control from the mem stage
//   pc_in, alu_in, uimm_in          candidate write-back values / effective address
//   br_en_in                        compare result (zero-extended when selected)
//   rd_in, load_regfile_in          destination register and its write request
//   regfilemux_sel, load_type_in    write-value select and load funct3
//   dcache_rdata                    registered data-cache read word
//   rf_we, rf_rd, rf_wdata          regfile write port (combinational)
//   fwd_valid, fwd_rd, fwd_data     last retired write (registered)
//   instret                         retired instruction count (registered)
//   misalign_err                    sticky misaligned-load flag (registered)
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  alu_in,
  input  logic [XLEN-1:0]  uimm_in,
  input  logic             br_en_in,
  input  logic [4:0]       rd_in,
  input  logic             load_regfile_in,
  input  logic [2:0]       regfilemux_sel,
  input  logic [2:0]       load_type_in,
  input  logic [XLEN-1:0]  dcache_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret,
  output logic             misalign_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [2:0] SEL_ALU  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_UIMM = 3'd2;
  localparam logic [2:0] SEL_LOAD = 3'd3;
  localparam logic [2:0] SEL_PC4  = 3'd4;

  // A squash still lets the WB instruction retire; only the stall matters here.
  logic unused_flush;
  assign unused_flush = flush_in;

  logic              retire;
  logic [1:0]        off;
  logic [BYTE_W-1:0] ld_byte;
  logic [HALF_W-1:0] ld_half;
  logic [XLEN-1:0]   ld_data;
  logic              misalign;

  logic              fwd_valid_q, fwd_valid_d;
  logic [4:0]        fwd_rd_q,    fwd_rd_d;
  logic [XLEN-1:0]   fwd_data_q,  fwd_data_d;
  logic [CNT_W-1:0]  instret_q,   instret_d;
  logic              misalign_q,  misalign_d;

  assign retire = valid_in & ~stall_in;
  assign off    = alu_in[1:0];

  // Load extraction; offsets are truncated to the containing word, never cross it.
  always_comb begin
    ld_byte = dcache_rdata[BYTE_W*off +: BYTE_W];
    ld_half = off[1] ? dcache_rdata[2*HALF_W-1:HALF_W] : dcache_rdata[HALF_W-1:0];
    case (load_type_in)
      LT_LB:   ld_data = {{(XLEN-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
      LT_LBU:  ld_data = {{(XLEN-BYTE_W){1'b0}}, ld_byte};
      LT_LH:   ld_data = {{(XLEN-HALF_W){ld_half[HALF_W-1]}}, ld_half};
      LT_LHU:  ld_data = {{(XLEN-HALF_W){1'b0}}, ld_half};
      default: ld_data = dcache_rdata;
    endcase
  end

  // Only a load (mux selecting load data) can be misaligned.
  always_comb begin
    misalign = 1'b0;
    if (regfilemux_sel == SEL_LOAD) begin
      case (load_type_in)
        LT_LH, LT_LHU: misalign = off[0];
        LT_LW:         misalign = (off != 2'b00);
        default:       misalign = 1'b0;
      endcase
    end
  end

  // Regfile write-value select; unused selects fall back to the ALU result.
  always_comb begin
    case (regfilemux_sel)
      SEL_ALU:  rf_wdata = alu_in;
      SEL_BR:   rf_wdata = XLEN'(br_en_in);
      SEL_UIMM: rf_wdata = uimm_in;
      SEL_LOAD: rf_wdata = ld_data;
      SEL_PC4:  rf_wdata = pc_in + XLEN'(4);
      default:  rf_wdata = alu_in;
    endcase
  end

  // x0 is never written; the write is suppressed while reset is held.
  assign rf_we = reset_n & retire & load_regfile_in & (rd_in != 5'd0);
  assign rf_rd = rd_in;

  // Next state for forwarding history, retire counter and error flag.
  always_comb begin
    fwd_valid_d = fwd_valid_q;
    fwd_rd_d    = fwd_rd_q;
    fwd_data_d  = fwd_data_q;
    instret_d   = instret_q;
    misalign_d  = misalign_q;
    if (rf_we) begin
      fwd_valid_d = 1'b1;
      fwd_rd_d    = rf_rd;
      fwd_data_d  = rf_wdata;
    end else if (retire) begin
      fwd_valid_d = 1'b0;
    end
    if (retire) begin
      instret_d  = instret_q + CNT_W'(1);
      misalign_d = misalign_q | misalign;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= 5'd0;
      fwd_data_q  <= '0;
      instret_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
      instret_q   <= instret_d;
      misalign_q  <= misalign_d;
    end
  end

  assign fwd_valid    = fwd_valid_q;
  assign fwd_rd       = fwd_rd_q;
  assign fwd_data     = fwd_data_q;
  assign instret      = instret_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in, stall_in, flush_in;
  logic [31:0] pc_in, alu_in, uimm_in;
  logic        br_en_in;
  logic [4:0]  rd_in;
  logic        load_regfile_in;
  logic [2:0]  regfilemux_sel, load_type_in;
  logic [31:0] dcache_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;
  logic        misalign_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [63:0] exp_cnt;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .valid_in       (valid_in),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .pc_in          (pc_in),
    .alu_in         (alu_in),
    .uimm_in        (uimm_in),
    .br_en_in       (br_en_in),
    .rd_in          (rd_in),
    .load_regfile_in(load_regfile_in),
    .regfilemux_sel (regfilemux_sel),
    .load_type_in   (load_type_in),
    .dcache_rdata   (dcache_rdata),
    .rf_we          (rf_we),
    .rf_rd          (rf_rd),
    .rf_wdata       (rf_wdata),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
    .instret        (instret),
    .misalign_err   (misalign_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] sel, input logic [4:0] rd,
                        input logic [2:0] lt, input logic [31:0] alu);
    regfilemux_sel  = sel;
    rd_in           = rd;
    load_type_in    = lt;
    alu_in          = alu;
    load_regfile_in = 1'b1;
    valid_in        = 1'b1;
    stall_in        = 1'b0;
    flush_in        = 1'b0;
  endtask

  // Check the write port, clock once, then check counter and forwarding state.
  task automatic exec(input string tag, input logic exp_we, input logic [31:0] exp_wd,
                      input logic exp_ret);
    logic [4:0] rd_now;
    rd_now = rd_in;
    #1;
    check({tag, ".we"}, 64'(rf_we), 64'(exp_we));
    check({tag, ".wd"}, 64'(rf_wdata), 64'(exp_wd));
    check({tag, ".rd"}, 64'(rf_rd), 64'(rd_now));
    tick;
    if (exp_ret) exp_cnt = exp_cnt + 64'd1;
    check({tag, ".cnt"}, instret, exp_cnt);
    if (exp_we) begin
      check({tag, ".fv"}, 64'(fwd_valid), 64'd1);
      check({tag, ".frd"}, 64'(fwd_rd), 64'(rd_now));
      check({tag, ".fd"}, 64'(fwd_data), 64'(exp_wd));
    end
  endtask

  task automatic check_fwd(input string tag, input logic v, input logic [4:0] rd,
                           input logic [31:0] d);
    check({tag, ".fv"}, 64'(fwd_valid), 64'(v));
    check({tag, ".frd"}, 64'(fwd_rd), 64'(rd));
    check({tag, ".fd"}, 64'(fwd_data), 64'(d));
  endtask

  initial begin
    reset_n = 1'b0;
    valid_in = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    pc_in = 32'h0000_1000; alu_in = 32'h0; uimm_in = 32'h0; br_en_in = 1'b0;
    rd_in = 5'd5; load_regfile_in = 1'b1; regfilemux_sel = 3'd0; load_type_in = 3'b010;
    dcache_rdata = 32'h0;
    exp_cnt = 64'd0;

    // Reset holds write enable low even with a writing instruction present.
    #3;
    check("rst.we", 64'(rf_we), 64'd0);
    check("rst.cnt", instret, 64'd0);
    check("rst.fv", 64'(fwd_valid), 64'd0);
    check("rst.frd", 64'(fwd_rd), 64'd0);
    check("rst.fd", 64'(fwd_data), 64'd0);
    check("rst.mis", 64'(misalign_err), 64'd0);
    tick;
    valid_in = 1'b0;
    reset_n  = 1'b1;
    tick;
    check("post_rst.cnt", instret, 64'd0);

    // Load extraction from 80FF_7F01.
    dcache_rdata = 32'h80FF_7F01;
    set_op(3'd3, 5'd1, 3'b000, 32'h0000_0101); exec("lb_off1", 1'b1, 32'h0000_007F, 1'b1);
    set_op(3'd3, 5'd2, 3'b000, 32'h0000_0103); exec("lb_off3", 1'b1, 32'hFFFF_FF80, 1'b1);
    set_op(3'd3, 5'd3, 3'b101, 32'h0000_0102); exec("lhu_off2", 1'b1, 32'h0000_80FF, 1'b1);
    set_op(3'd3, 5'd4, 3'b010, 32'h0000_0100); exec("lw", 1'b1, 32'h80FF_7F01, 1'b1);
    set_op(3'd3, 5'd4, 3'b001, 32'h0000_0102); exec("lh_off2", 1'b1, 32'hFFFF_80FF, 1'b1);
    set_op(3'd3, 5'd4, 3'b100, 32'h0000_0103); exec("lbu_off3", 1'b1, 32'h0000_0080, 1'b1);
    set_op(3'd3, 5'd4, 3'b011, 32'h0000_0101); exec("lt_undef", 1'b1, 32'h80FF_7F01, 1'b1);
    check("aligned.mis", 64'(misalign_err), 64'd0);

    // Mux selects, PC+4 wrap and x0 suppression.
    pc_in = 32'hFFFF_FFFC;
    set_op(3'd4, 5'd5, 3'b010, 32'h0); exec("pc4_wrap", 1'b1, 32'h0, 1'b1);
    br_en_in = 1'b1;
    set_op(3'd1, 5'd6, 3'b010, 32'h0); exec("br_en", 1'b1, 32'h1, 1'b1);
    set_op(3'd5, 5'd6, 3'b010, 32'h0000_0ABC); exec("sel5", 1'b1, 32'h0000_0ABC, 1'b1);
    set_op(3'd0, 5'd0, 3'b010, 32'h0000_1234); exec("rd0", 1'b0, 32'h0000_1234, 1'b1);
    check_fwd("rd0", 1'b0, 5'd6, 32'h0000_0ABC);

    // Three valid cycles with a stall on the second: two retires, fwd held.
    uimm_in = 32'hABCD_0000;
    set_op(3'd2, 5'd7, 3'b010, 32'h0); exec("stl_a", 1'b1, 32'hABCD_0000, 1'b1);
    set_op(3'd0, 5'd8, 3'b010, 32'h0000_0099); stall_in = 1'b1;
    exec("stl_b", 1'b0, 32'h0000_0099, 1'b0);
    check_fwd("stl_b", 1'b1, 5'd7, 32'hABCD_0000);
    set_op(3'd0, 5'd9, 3'b010, 32'h0000_0055); exec("stl_c", 1'b1, 32'h0000_0055, 1'b1);

    // Flush alone retires; flush with stall does not; bubble holds.
    set_op(3'd0, 5'd10, 3'b010, 32'h0000_0077); flush_in = 1'b1;
    exec("flush", 1'b1, 32'h0000_0077, 1'b1);
    set_op(3'd0, 5'd11, 3'b010, 32'h0000_0088); flush_in = 1'b1; stall_in = 1'b1;
    exec("stl_flush", 1'b0, 32'h0000_0088, 1'b0);
    check_fwd("stl_flush", 1'b1, 5'd10, 32'h0000_0077);
    set_op(3'd0, 5'd12, 3'b010, 32'h0000_0066); valid_in = 1'b0;
    exec("bubble", 1'b0, 32'h0000_0066, 1'b0);
    check_fwd("bubble", 1'b1, 5'd10, 32'h0000_0077);

    // Misaligned lw still writes the whole word and sets the sticky flag.
    dcache_rdata = 32'h1234_5678;
    set_op(3'd3, 5'd13, 3'b010, 32'h0000_1002); exec("mis_lw", 1'b1, 32'h1234_5678, 1'b1);
    check("mis_lw.flag", 64'(misalign_err), 64'd1);
    for (int i = 0; i < 10; i++) begin
      dcache_rdata = 32'hC0DE_0000 + 32'(i);
      set_op(3'd3, 5'd14, 3'b010, 32'h0000_2000 + 32'(4 * i));
      exec("al_lw", 1'b1, 32'hC0DE_0000 + 32'(i), 1'b1);
    end
    check("mis_sticky", 64'(misalign_err), 64'd1);

    // Counter wrap from all-ones.
    valid_in = 1'b0;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    check("wrap.pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    set_op(3'd0, 5'd15, 3'b010, 32'h0000_0001); exec("wrap", 1'b1, 32'h0000_0001, 1'b1);
    check("wrap.zero", instret, 64'd0);

    // Async reset during a stall clears state between clock edges.
    set_op(3'd0, 5'd16, 3'b010, 32'h0000_0002); stall_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.we", 64'(rf_we), 64'd0);
    check("arst.cnt", instret, 64'd0);
    check("arst.mis", 64'(misalign_err), 64'd0);
    check_fwd("arst", 1'b0, 5'd0, 32'h0);
    valid_in = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    check("arst.mis_after", 64'(misalign_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
